// File: rtl/multdiv_issue_ctrl.sv
// Issues one mult/div to multdiv with held operands, stalls the pipe until a result or timeout.
// Latency: RDY at WAIT count N gives wb_valid N+3 cycles after issue; DONE holds until wb_ready.
module multdiv_issue_ctrl #(
  parameter int MIN_WAIT   = 2,
  parameter int TIMEOUT    = 40,
  parameter int STATUS_REG = 30,
  parameter int EXC_MULT   = 4,
  parameter int EXC_DIV    = 5
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [31:0] issue_opA,
  input  logic [31:0] issue_opB,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  input  logic        wb_ready,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [31:0]     op_a, op_b, res;
  logic [4:0]      rd;
  logic            is_div, exc;
  logic [CW-1:0]   cnt;
  logic            ctrl_mult_q, ctrl_div_q;
  logic            rdy_ok, timed_out;

  // multdiv's counter is not settled for the first MIN_WAIT cycles, so early RDY is noise
  assign rdy_ok    = md_resultRDY && (cnt >= CW'(MIN_WAIT));
  assign timed_out = (cnt == CW'(TIMEOUT));

  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    wb_valid  = 1'b0;
    wb_we     = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'd0;
    case (state)
      S_IDLE: begin
        stall = issue_valid;
        if (issue_valid) state_nxt = S_START;
      end
      S_START: begin
        stall     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (rdy_ok || timed_out) state_nxt = S_DONE;
      end
      S_DONE: begin
        wb_valid = 1'b1;
        stall    = ~wb_ready;
        if (exc) begin
          wb_rd   = 5'(STATUS_REG);
          wb_data = is_div ? 32'(EXC_DIV) : 32'(EXC_MULT);
          wb_we   = 1'b1;
        end else begin
          wb_rd   = rd;
          wb_data = res;
          wb_we   = (rd != 5'd0);
        end
        if (wb_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      op_a        <= 32'd0;
      op_b        <= 32'd0;
      rd          <= 5'd0;
      is_div      <= 1'b0;
      res         <= 32'd0;
      exc         <= 1'b0;
      cnt         <= '0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
    end else begin
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue_valid) begin
            op_a        <= issue_opA;
            op_b        <= issue_opB;
            rd          <= issue_rd;
            is_div      <= issue_is_div;
            ctrl_div_q  <= issue_is_div;
            ctrl_mult_q <= ~issue_is_div;
          end
        end
        S_START: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + CW'(1);
          if (rdy_ok) begin
            res <= md_result;
            exc <= md_exception;
          end else if (timed_out) begin
            res <= 32'd0;
            exc <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // operands stay on the bus from capture through writeback since multdiv re-latches each cycle
  assign md_operandA = op_a;
  assign md_operandB = op_b;
  assign ctrl_MULT   = ctrl_mult_q;
  assign ctrl_DIV    = ctrl_div_q;
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Randomized bench for multdiv_issue_ctrl; a multdiv stub answers at a chosen WAIT count.
module tb_multdiv_issue_ctrl;

  localparam int MIN_WAIT   = 2;
  localparam int TIMEOUT    = 40;
  localparam int STATUS_REG = 30;
  localparam int EXC_MULT   = 4;
  localparam int EXC_DIV    = 5;

  logic        clock = 1'b0;
  logic        resetn;
  logic        issue_valid, issue_is_div;
  logic [31:0] issue_opA, issue_opB;
  logic [4:0]  issue_rd;
  logic [31:0] md_result;
  logic        md_exception, md_resultRDY, wb_ready;
  logic [31:0] md_operandA, md_operandB;
  logic        ctrl_MULT, ctrl_DIV, stall, busy, wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int failures = 0;

  multdiv_issue_ctrl #(
    .MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT), .STATUS_REG(STATUS_REG),
    .EXC_MULT(EXC_MULT), .EXC_DIV(EXC_DIV)
  ) dut (
    .clock(clock), .resetn(resetn),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div),
    .issue_opA(issue_opA), .issue_opB(issue_opB), .issue_rd(issue_rd),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .wb_ready(wb_ready),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .stall(stall), .busy(busy),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Arithmetic reference for what a correct multdiv would report.
  task automatic ref_md(input bit div, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output bit exc);
    longint p;
    if (div) begin
      if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hffff_ffff)) begin
        res = 32'd0;
        exc = 1'b1;
      end else begin
        res = $signed(a) / $signed(b);
        exc = 1'b0;
      end
    end else begin
      p   = longint'($signed(a)) * longint'($signed(b));
      res = p[31:0];
      exc = (p != longint'($signed(res)));
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_wbv"}, 32'(wb_valid), 32'd0);
    check({tag, "_wbwe"}, 32'(wb_we), 32'd0);
    check({tag, "_wbrd"}, 32'(wb_rd), 32'd0);
    check({tag, "_wbdat"}, wb_data, 32'd0);
    check({tag, "_mult"}, 32'(ctrl_MULT), 32'd0);
    check({tag, "_div"}, 32'(ctrl_DIV), 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_opa"}, md_operandA, 32'd0);
    check({tag, "_opb"}, md_operandB, 32'd0);
  endtask

  // n = WAIT count of the real RDY (> TIMEOUT means never); hold = DONE cycles with wb_ready low;
  // abort_at > 0 pulls reset at that cycle after issue instead of completing.
  task automatic run_op(input bit div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input int n, input int hold,
                        input bit early, input int abort_at);
    logic [31:0] exp_res, exp_data;
    logic [4:0]  exp_rd;
    bit          exp_exc, exp_we;
    int          d, k;
    ref_md(div, a, b, exp_res, exp_exc);
    d = (n > TIMEOUT) ? TIMEOUT + 3 : n + 3;
    if (n > TIMEOUT || exp_exc) begin
      exp_rd = 5'(STATUS_REG);
      exp_data = div ? 32'(EXC_DIV) : 32'(EXC_MULT);
      exp_we = 1'b1;
    end else begin
      exp_rd = r;
      exp_data = exp_res;
      exp_we = (r != 5'd0);
    end

    @(negedge clock);
    issue_valid = 1'b1; issue_is_div = div; issue_opA = a; issue_opB = b; issue_rd = r;
    md_resultRDY = 1'b0; wb_ready = 1'($urandom);
    #1;
    check("issue_busy", 32'(busy), 32'd0);
    check("issue_stall", 32'(stall), 32'd1);

    for (int c = 1; c < d; c++) begin
      @(negedge clock);
      if (abort_at > 0 && c == abort_at) begin
        resetn = 1'b0; issue_valid = 1'b0;
        @(negedge clock);
        #1;
        check_idle_zero("rst_abort");
        resetn = 1'b1;
        for (int j = 0; j < 6; j++) begin
          @(negedge clock);
          md_resultRDY = 1'b1; md_result = $urandom; md_exception = 1'($urandom);
          wb_ready = 1'b1;
          #1;
          check("late_rdy_wbv", 32'(wb_valid), 32'd0);
          check("late_rdy_busy", 32'(busy), 32'd0);
        end
        md_resultRDY = 1'b0;
        return;
      end
      issue_valid = 1'($urandom); issue_is_div = 1'($urandom);
      issue_opA = $urandom; issue_opB = $urandom; issue_rd = 5'($urandom);
      wb_ready = 1'($urandom);
      k = c - 2;
      md_resultRDY = (k == n) || (k >= 0 && k < MIN_WAIT && (early || 1'($urandom)));
      md_result    = (k == n) ? exp_res : $urandom;
      md_exception = (k == n) ? exp_exc : 1'($urandom);
      #1;
      check("pulse_mult", 32'(ctrl_MULT), 32'(c == 1 && !div));
      check("pulse_div", 32'(ctrl_DIV), 32'(c == 1 && div));
      check("run_stall", 32'(stall), 32'd1);
      check("run_busy", 32'(busy), 32'd1);
      check("run_wbv", 32'(wb_valid), 32'd0);
      check("run_opa", md_operandA, a);
      check("run_opb", md_operandB, b);
    end

    for (int h = 0; h <= hold; h++) begin
      @(negedge clock);
      issue_valid = 1'($urandom); issue_opA = $urandom; issue_opB = $urandom;
      md_resultRDY = 1'($urandom); md_result = $urandom; md_exception = 1'($urandom);
      wb_ready = (h == hold);
      #1;
      check("done_wbv", 32'(wb_valid), 32'd1);
      check("done_we", 32'(wb_we), 32'(exp_we));
      check("done_rd", 32'(wb_rd), 32'(exp_rd));
      check("done_data", wb_data, exp_data);
      check("done_stall", 32'(stall), 32'(h != hold));
      check("done_busy", 32'(busy), 32'd1);
      check("done_opa", md_operandA, a);
      check("done_opb", md_operandB, b);
      check("done_pulse", 32'(ctrl_MULT | ctrl_DIV), 32'd0);
    end

    @(negedge clock);
    issue_valid = 1'b0; md_resultRDY = 1'($urandom); wb_ready = 1'($urandom);
    #1;
    check("post_busy", 32'(busy), 32'd0);
    check("post_wbv", 32'(wb_valid), 32'd0);
    check("post_stall", 32'(stall), 32'd0);
    check("post_pulse", 32'(ctrl_MULT | ctrl_DIV), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; issue_valid = 1'b1; issue_is_div = 1'b0; issue_opA = 32'd3; issue_opB = 32'd4;
    issue_rd = 5'd1; md_result = 32'd0; md_exception = 1'b0; md_resultRDY = 1'b1; wb_ready = 1'b1;
    repeat (2) @(negedge clock);
    issue_valid = 1'b0;
    #1;
    check_idle_zero("reset");
    resetn = 1'b1;

    run_op(1'b0, 32'd7, 32'hffff_fffd, 5'd5, 4, 0, 1'b0, 0);
    run_op(1'b1, 32'd100, 32'd7, 5'd9, 6, 1, 1'b0, 0);
    run_op(1'b1, 32'd5, 32'd0, 5'd12, 3, 0, 1'b0, 0);
    run_op(1'b0, 32'h4000_0000, 32'd4, 5'd3, 2, 0, 1'b0, 0);
    run_op(1'b0, 32'd11, 32'd13, 5'd7, 33, 0, 1'b1, 0);
    run_op(1'b0, 32'd2, 32'd3, 5'd4, 99, 0, 1'b0, 0);
    run_op(1'b1, 32'd9, 32'd3, 5'd4, 99, 2, 1'b0, 0);
    run_op(1'b0, 32'd6, 32'd6, 5'd0, 5, 5, 1'b0, 0);
    run_op(1'b1, 32'd50, 32'd5, 5'd8, TIMEOUT, 0, 1'b1, 0);
    run_op(1'b1, 32'd1000, 32'd3, 5'd10, 99, 0, 1'b0, 12);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] a, b;
      a = ($urandom % 4 == 0) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
      b = ($urandom % 8 == 0) ? 32'd0 : (($urandom % 4 == 0) ? $urandom
                                         : 32'($urandom_range(1, 300)));
      run_op(1'($urandom), a, b, 5'($urandom), $urandom_range(MIN_WAIT, TIMEOUT + 5),
             $urandom_range(0, 4), 1'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
